server_lookup_ingress: RTL and testbench
========================================

# server_lookup_ingress

Ingress classifier between a server/MAC receive AXI-Stream and the ToR forwarding logic. Buffers each frame, extracts the destination MAC from the first beat and issues a request to the MAC lookup stage. It pairs the returned outport and seek flag with the buffered frame, then replays the frame downstream with that routing sideband held for the whole packet. Upstream has no backpressure, so the block drops whole packets it cannot buffer.

## Interface
- P_DATA_DEPTH, 512, data FIFO depth in beats (power of 2)
- P_META_DEPTH, 8, result FIFO depth = max packets buffered/outstanding (power of 2)
- P_MAX_PKT_BEATS, 192, max stored beats per packet; also the SOP free-space threshold
- P_LOOKUP_TIMEOUT, 16, cycles to wait for a lookup result before defaulting
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- s_axis_tvalid / tdata / tkeep / tlast / tuser  in  1/64/8/1/1  ingress stream, no tready; tuser ignored
- o_check_mac  out  48  destination MAC to look up
- o_check_id  out  4  request id, 1..15, never 0
- o_check_valid  out  1  request strobe, single cycle
- i_outport  in  3  lookup result port
- i_seek_flag  in  2  lookup result class: 0 DDR, 1 crossbar, 2 two-hop FIFO, 3 VLB
- i_check_id  in  4  id of returned result
- i_result_valid  in  1  result strobe
- m_axis_tvalid / tdata / tkeep / tlast  out  1/64/8/1  egress stream
- m_axis_tready  in  1  egress ready
- o_m_outport  out  3  routing port, stable while a packet is on m_axis
- o_m_seek_flag  out  2  routing class, stable while a packet is on m_axis
- o_drop_cnt, o_timeout_cnt, o_id_err_cnt  out  16 each  saturating statistics

## Operation
- Ingress SOP = first valid beat after reset or after a tlast beat.
- SOP accepts the packet only if data FIFO free ≥ P_MAX_PKT_BEATS and (outstanding lookups + meta entries) < P_META_DEPTH. Otherwise discard every beat through tlast and add 1 to o_drop_cnt.
- On an accepted SOP, o_check_mac = tdata[63:16]. The id counter advances 1→15→1, skipping 0. o_check_id keeps the last issued value between requests.
- Beats are written to the data FIFO as {tlast,tkeep,tdata}. If beat P_MAX_PKT_BEATS arrives without tlast, write it with tlast forced to 1 and discard the rest of the packet. Add 1 to o_drop_cnt.
- Results return in issue order. The expected id equals the oldest outstanding id.
  - If i_result_valid and i_check_id matches the expected id, push {i_outport,i_seek_flag} to the meta FIFO and retire the oldest lookup.
  - If the id does not match, or nothing is outstanding, discard the result and add 1 to o_id_err_cnt.
- Timeout: one timer runs on the oldest outstanding lookup and restarts on retire. When it reaches P_LOOKUP_TIMEOUT:
  - push {3'd0,2'd0}, which routes the packet to the DDR queue;
  - retire the lookup;
  - add 1 to o_timeout_cnt.
  - A late result for that id is then discarded as an id error.
- Egress FSM:
  - E_IDLE → E_SEND when the meta FIFO is not empty. Pop the meta entry and latch o_m_outport/o_m_seek_flag.
  - E_SEND: m_axis carries data FIFO head; a beat pops on tvalid&tready.
  - On a tlast handshake, go to E_IDLE. tvalid must not drop mid-packet except while the data FIFO is empty.
- Statistics counters saturate at 16'hFFFF.

## Timing
- Reset values:
  - m_axis_tvalid, tdata, tkeep, tlast = 0; o_m_outport, o_m_seek_flag = 0.
  - o_check_valid = 0, o_check_mac = 0, o_check_id = 1.
  - All counters = 0. FSM = E_IDLE. Both FIFOs empty.
  - Ingress SOP tracker = expecting SOP. Id counter = 1.
- o_check_valid is registered. It is asserted the cycle after the accepted SOP beat.
- The lookup stage returns its result 2 cycles after o_check_valid. The timeout must exceed this latency.
- Earliest m_axis first beat is 2 cycles after the meta push: pop/latch, then first beat.
- Result push, timeout push and a new request in the same cycle are all legal. Counters and occupancy update correctly.
- An SOP is accepted in the same cycle as egress pops. The occupancy check uses pre-pop values, which is conservative.
- A reset mid-packet flushes all state. The next ingress valid beat is treated as SOP.

## Structure
- Package server_lookup_pkg: egress state encoding, seek-flag constants (SEEK_DDR=0, SEEK_XBAR=1, SEEK_TWOHOP=2, SEEK_VLB=3), MAC field offsets, default timeout result.
- Sub-module sync_fifo (parameterised width/depth, exposes count). It is instantiated twice: data FIFO 73 bits, meta FIFO 5 bits.

## Test plan
- 128-beat packet, dest MAC 48'h8DBC5C4A_0102, lookup returns outport 2 / seek 1 after 2 cycles → 128 beats on m_axis, tlast on beat 128, o_m_outport=2, o_m_seek_flag=1, counters 0.
- 16 back-to-back packets → ids 1..15 then 1. o_check_id never 0.
- Random m_axis_tready deasserted 50% of cycles → data identical. Sideband stable per packet. Once the FIFO fills, excess packets are dropped whole with o_drop_cnt incremented. No partial packets.
- Lookup never responds → after 16 cycles default result: outport 0, seek 0. o_timeout_cnt=1. A late result gives o_id_err_cnt=1.
- 200-beat packet with P_MAX_PKT_BEATS=192 → 192 beats out, tlast on beat 192, o_drop_cnt=1.
- Reset asserted during beat 40 of a packet → all outputs at reset values. The next packet is processed normally with id 1.

Source files
------------

// File: rtl/server_lookup_pkg.sv
// Shared types and constants for the server lookup ingress block.
package server_lookup_pkg;

  // Egress replay FSM encoding.
  typedef enum logic {
    E_IDLE = 1'b0,
    E_SEND = 1'b1
  } egress_state_t;

  // Lookup result classes returned alongside the outport.
  localparam logic [1:0] SEEK_DDR    = 2'd0;
  localparam logic [1:0] SEEK_XBAR   = 2'd1;
  localparam logic [1:0] SEEK_TWOHOP = 2'd2;
  localparam logic [1:0] SEEK_VLB    = 2'd3;

  // Destination MAC location inside the first beat of a frame.
  localparam int MAC_HI = 63;
  localparam int MAC_LO = 16;

  // Result used when the lookup stage never answers: outport 0, DDR queue.
  localparam logic [4:0] DEFAULT_RESULT = {3'd0, SEEK_DDR};

  // Statistics counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Request ids cycle 1..15; id 0 is never used on the lookup interface.
  function automatic logic [3:0] next_id(input logic [3:0] id);
    return (id == 4'd15) ? 4'd1 : id + 4'd1;
  endfunction

endpackage

// File: rtl/server_lookup_ingress_fifo.sv
// Single-clock show-ahead FIFO: o_rd_data is the current head, o_count is
// the occupancy before this cycle's push/pop take effect.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_wr_en,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_rd_en,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign o_empty   = (o_count == '0);
  assign o_full    = (o_count == (AW+1)'(DEPTH));
  assign wr_ok     = i_wr_en && !o_full;
  assign rd_ok     = i_rd_en && !o_empty;
  assign o_rd_data = mem[rd_ptr];

  // Storage array; contents need no reset because count gates every read.
  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wr_ptr] <= i_wr_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      o_count <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   o_count <= o_count + (AW+1)'(1);
        2'b01:   o_count <= o_count - (AW+1)'(1);
        default: o_count <= o_count;
      endcase
    end
  end

endmodule

// File: rtl/server_lookup_ingress.sv
// Ingress classifier: buffers frames, looks up the destination MAC, and
// replays each frame with its routing sideband held for the whole packet.
//
// Handshake: s_axis has no ready, a beat transfers whenever tvalid is high.
// m_axis transfers a beat on a cycle where tvalid and tready are both high;
// once tvalid rises inside a packet it only falls if the data FIFO runs dry.
// o_check_valid and i_result_valid are single-cycle strobes with no ready.
module server_lookup_ingress
  import server_lookup_pkg::*;
#(
  parameter int P_DATA_DEPTH     = 512,
  parameter int P_META_DEPTH     = 8,
  parameter int P_MAX_PKT_BEATS  = 192,
  parameter int P_LOOKUP_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        s_axis_tvalid,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [47:0] o_check_mac,
  output logic [3:0]  o_check_id,
  output logic        o_check_valid,
  input  logic [2:0]  i_outport,
  input  logic [1:0]  i_seek_flag,
  input  logic [3:0]  i_check_id,
  input  logic        i_result_valid,
  output logic        m_axis_tvalid,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  output logic [2:0]  o_m_outport,
  output logic [1:0]  o_m_seek_flag,
  output logic [15:0] o_drop_cnt,
  output logic [15:0] o_timeout_cnt,
  output logic [15:0] o_id_err_cnt,
  output logic        o_egress_state
);

  localparam int DAW = $clog2(P_DATA_DEPTH);
  localparam int MAW = $clog2(P_META_DEPTH);
  localparam int BCW = $clog2(P_MAX_PKT_BEATS + 1);
  localparam int TW  = $clog2(P_LOOKUP_TIMEOUT + 1);

  // FIFO plumbing
  logic [DAW:0]   data_count;
  logic           data_empty;
  logic [72:0]    data_head;
  logic [72:0]    data_wr_data;
  logic           data_wr_en;
  logic           data_rd_en;
  logic [MAW:0]   meta_count;
  logic           meta_empty;
  logic [4:0]     meta_head;
  logic [4:0]     meta_wr_data;
  logic           meta_wr_en;
  logic           meta_rd_en;
  logic           unused_data_full;
  logic           unused_meta_full;
  logic           unused_tuser;

  // Ingress tracking
  logic           in_pkt;
  logic           discard;
  logic [BCW-1:0] beat_cnt;
  logic [BCW-1:0] beat_num;
  logic [DAW:0]   data_free;
  logic           sop;
  logic           space_ok;
  logic           slot_ok;
  logic           accept;
  logic           trunc;
  logic           drop_evt;

  // Lookup tracking
  logic [3:0]     id_cnt;
  logic [3:0]     oldest_id;
  logic [MAW:0]   outstanding;
  logic [TW-1:0]  timer;
  logic           res_match;
  logic           tmo_fire;
  logic           retire;
  logic           id_err_evt;

  // Egress FSM
  egress_state_t  state_q;
  egress_state_t  state_d;
  logic           data_hs;

  assign unused_tuser   = s_axis_tuser;
  assign o_egress_state = state_q;

  // Admission and truncation decisions for the current ingress beat.
  always_comb begin
    sop       = s_axis_tvalid && !in_pkt;
    data_free = (DAW+1)'(P_DATA_DEPTH) - data_count;
    space_ok  = data_free >= (DAW+1)'(P_MAX_PKT_BEATS);
    slot_ok   = ({1'b0, outstanding} + {1'b0, meta_count}) < (MAW+2)'(P_META_DEPTH);
    accept    = sop && space_ok && slot_ok;
    beat_num  = sop ? BCW'(1) : beat_cnt + BCW'(1);
    data_wr_en = accept || (s_axis_tvalid && in_pkt && !discard);
    trunc     = data_wr_en && !s_axis_tlast && (beat_num == BCW'(P_MAX_PKT_BEATS));
    drop_evt  = (sop && !accept) || trunc;
    data_wr_data = {s_axis_tlast || trunc, s_axis_tkeep, s_axis_tdata};
  end

  // Packet boundary tracker: SOP detection, beat count and discard mode.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      in_pkt   <= 1'b0;
      discard  <= 1'b0;
      beat_cnt <= '0;
    end else if (s_axis_tvalid) begin
      if (!in_pkt) begin
        in_pkt   <= !s_axis_tlast;
        discard  <= !accept || trunc;
        beat_cnt <= BCW'(1);
      end else begin
        if (s_axis_tlast) in_pkt <= 1'b0;
        if (!discard) begin
          beat_cnt <= beat_num;
          if (trunc) discard <= 1'b1;
        end
      end
    end
  end

  // Lookup request issue, registered one cycle after the accepted SOP.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_check_valid <= 1'b0;
      o_check_mac   <= '0;
      o_check_id    <= 4'd1;
      id_cnt        <= 4'd1;
    end else begin
      o_check_valid <= accept;
      if (accept) begin
        o_check_mac <= s_axis_tdata[MAC_HI:MAC_LO];
        o_check_id  <= id_cnt;
        id_cnt      <= next_id(id_cnt);
      end
    end
  end

  // Results come back in issue order, so only the oldest id can match.
  always_comb begin
    res_match    = i_result_valid && (outstanding != '0) && (i_check_id == oldest_id);
    tmo_fire     = (outstanding != '0) && !res_match &&
                   (timer == TW'(P_LOOKUP_TIMEOUT - 1));
    retire       = res_match || tmo_fire;
    id_err_evt   = i_result_valid && !res_match;
    meta_wr_en   = retire;
    meta_wr_data = res_match ? {i_outport, i_seek_flag} : DEFAULT_RESULT;
  end

  // Outstanding lookup count, oldest id and the timer on the oldest lookup.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      outstanding <= '0;
      oldest_id   <= 4'd1;
      timer       <= '0;
    end else begin
      case ({accept, retire})
        2'b10:   outstanding <= outstanding + (MAW+1)'(1);
        2'b01:   outstanding <= outstanding - (MAW+1)'(1);
        default: outstanding <= outstanding;
      endcase
      if (retire) oldest_id <= next_id(oldest_id);
      if (retire || outstanding == '0) timer <= '0;
      else                             timer <= timer + TW'(1);
    end
  end

  // Saturating statistics.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_drop_cnt    <= '0;
      o_timeout_cnt <= '0;
      o_id_err_cnt  <= '0;
    end else begin
      if (drop_evt)   o_drop_cnt    <= sat_inc(o_drop_cnt);
      if (tmo_fire)   o_timeout_cnt <= sat_inc(o_timeout_cnt);
      if (id_err_evt) o_id_err_cnt  <= sat_inc(o_id_err_cnt);
    end
  end

  // Egress state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= E_IDLE;
    else       state_q <= state_d;
  end

  // Egress next state, FIFO pops and stream outputs.
  always_comb begin
    state_d       = state_q;
    meta_rd_en    = 1'b0;
    data_rd_en    = 1'b0;
    m_axis_tvalid = (state_q == E_SEND) && !data_empty;
    m_axis_tdata  = m_axis_tvalid ? data_head[63:0]  : 64'd0;
    m_axis_tkeep  = m_axis_tvalid ? data_head[71:64] : 8'd0;
    m_axis_tlast  = m_axis_tvalid && data_head[72];
    data_hs       = m_axis_tvalid && m_axis_tready;
    case (state_q)
      E_IDLE: begin
        if (!meta_empty) begin
          meta_rd_en = 1'b1;
          state_d    = E_SEND;
        end
      end
      E_SEND: begin
        if (data_hs) begin
          data_rd_en = 1'b1;
          if (data_head[72]) state_d = E_IDLE;
        end
      end
      default: state_d = E_IDLE;
    endcase
  end

  // Routing sideband captured with the meta pop, held for the whole packet.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_m_outport   <= '0;
      o_m_seek_flag <= '0;
    end else if (meta_rd_en) begin
      {o_m_outport, o_m_seek_flag} <= meta_head;
    end
  end

  sync_fifo #(.WIDTH(73), .DEPTH(P_DATA_DEPTH)) u_data_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (data_wr_en),
    .i_wr_data (data_wr_data),
    .i_rd_en   (data_rd_en),
    .o_rd_data (data_head),
    .o_empty   (data_empty),
    .o_full    (unused_data_full),
    .o_count   (data_count)
  );

  sync_fifo #(.WIDTH(5), .DEPTH(P_META_DEPTH)) u_meta_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (meta_wr_en),
    .i_wr_data (meta_wr_data),
    .i_rd_en   (meta_rd_en),
    .o_rd_data (meta_head),
    .o_empty   (meta_empty),
    .o_full    (unused_meta_full),
    .o_count   (meta_count)
  );

endmodule

// File: tb/tb_server_lookup_ingress.sv
// Directed bench for server_lookup_ingress: scripted ingress packets, a
// lookup responder, and a scoreboard on the egress stream and requests.
module tb_server_lookup_ingress;

  localparam int MAX = 192;

  // Clock / reset
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;

  // DUT signals
  logic        s_axis_tvalid = 1'b0;
  logic [63:0] s_axis_tdata  = '0;
  logic [7:0]  s_axis_tkeep  = '0;
  logic        s_axis_tlast  = 1'b0;
  logic        s_axis_tuser  = 1'b0;
  logic [47:0] o_check_mac;
  logic [3:0]  o_check_id;
  logic        o_check_valid;
  logic [2:0]  i_outport      = '0;
  logic [1:0]  i_seek_flag    = '0;
  logic [3:0]  i_check_id     = '0;
  logic        i_result_valid = 1'b0;
  logic        m_axis_tvalid;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tready = 1'b0;
  logic [2:0]  o_m_outport;
  logic [1:0]  o_m_seek_flag;
  logic [15:0] o_drop_cnt;
  logic [15:0] o_timeout_cnt;
  logic [15:0] o_id_err_cnt;
  logic        o_egress_state;

  server_lookup_ingress #(
    .P_DATA_DEPTH(512), .P_META_DEPTH(8), .P_MAX_PKT_BEATS(MAX), .P_LOOKUP_TIMEOUT(16)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .o_check_mac(o_check_mac), .o_check_id(o_check_id), .o_check_valid(o_check_valid),
    .i_outport(i_outport), .i_seek_flag(i_seek_flag), .i_check_id(i_check_id),
    .i_result_valid(i_result_valid),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
    .o_m_outport(o_m_outport), .o_m_seek_flag(o_m_seek_flag),
    .o_drop_cnt(o_drop_cnt), .o_timeout_cnt(o_timeout_cnt), .o_id_err_cnt(o_id_err_cnt),
    .o_egress_state(o_egress_state)
  );

  // Scoreboard state
  int tests = 0;
  int fails = 0;
  logic [72:0] exp_q[$];      // {tlast,tkeep,tdata} per expected egress beat
  logic [4:0]  exp_sb_q[$];   // {outport,seek} per expected egress packet
  logic [51:0] exp_chk_q[$];  // {id,mac} per expected lookup request
  logic [3:0]  exp_id = 4'd1;
  int          pkt_seq = 0;
  int          beats_out = 0;
  int          tready_mode = 2;  // 0 hold low, 1 random, 2 always high
  bit          first_beat = 1'b1;
  logic [4:0]  cur_sb = '0;

  // Responder configuration: 0 silent, 1 fixed result, 2 result derived from id
  int          rsp_mode = 2;
  logic [2:0]  rsp_port = '0;
  logic [1:0]  rsp_seek = '0;
  int          inj_req_cnt = 0;
  int          inj_done_cnt = 0;
  logic [3:0]  inj_id = '0;

  task automatic check(input string tag, input logic [72:0] obs, input logic [72:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lookup stage model: answers 2 cycles after each o_check_valid.
  logic       d1_v = 1'b0, d2_v = 1'b0;
  logic [3:0] d1_id = '0, d2_id = '0;
  logic [4:0] d1_r = '0, d2_r = '0;
  always @(negedge i_clk) begin
    if (i_rst) begin
      d1_v = 1'b0; d2_v = 1'b0;
      i_result_valid = 1'b0; i_check_id = '0; i_outport = '0; i_seek_flag = '0;
    end else begin
      i_result_valid = d2_v;
      i_check_id     = d2_id;
      {i_outport, i_seek_flag} = d2_r;
      if (inj_req_cnt != inj_done_cnt) begin
        i_result_valid = 1'b1;
        i_check_id     = inj_id;
        {i_outport, i_seek_flag} = 5'b10111;
        inj_done_cnt   = inj_req_cnt;
      end
      d2_v = d1_v; d2_id = d1_id; d2_r = d1_r;
      d1_v  = o_check_valid && (rsp_mode != 0);
      d1_id = o_check_id;
      d1_r  = (rsp_mode == 1) ? {rsp_port, rsp_seek} : {o_check_id[2:0], o_check_id[3:2]};
    end
  end

  // Egress ready generation and beat/sideband scoreboard.
  always @(negedge i_clk) begin
    case (tready_mode)
      0:       m_axis_tready = 1'b0;
      1:       m_axis_tready = 1'($urandom_range(0, 1));
      default: m_axis_tready = 1'b1;
    endcase
    if (i_rst) begin
      first_beat = 1'b1;
    end else if (m_axis_tvalid && m_axis_tready) begin
      check("egress_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0)
        check("egress_beat", {m_axis_tlast, m_axis_tkeep, m_axis_tdata}, exp_q.pop_front());
      if (first_beat) begin
        check("sideband_expected", exp_sb_q.size() != 0, 1);
        if (exp_sb_q.size() != 0) cur_sb = exp_sb_q.pop_front();
        check("sideband", {o_m_outport, o_m_seek_flag}, cur_sb);
      end else begin
        check("sideband_stable", {o_m_outport, o_m_seek_flag}, cur_sb);
      end
      first_beat = m_axis_tlast;
      beats_out++;
    end
  end

  // Lookup request monitor.
  always @(negedge i_clk) begin
    if (!i_rst && o_check_valid) begin
      logic [51:0] e;
      check("check_expected", exp_chk_q.size() != 0, 1);
      if (exp_chk_q.size() != 0) begin
        e = exp_chk_q.pop_front();
        check("check_id", o_check_id, e[51:48]);
        check("check_mac", o_check_mac, e[47:0]);
      end
      check("check_id_nonzero", o_check_id == 4'd0, 0);
    end
  end

  // Driver: one packet, optional abort after abort_at beats (no tlast, no idle).
  task automatic send_pkt(input logic [47:0] mac, input int nbeats, input bit accept,
                          input int sb_sel, input int gap, input int abort_at);
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic [4:0]  sb;
    int          stop;
    stop = (abort_at > 0) ? abort_at : nbeats;
    pkt_seq++;
    for (int b = 0; b < stop; b++) begin
      @(negedge i_clk);
      d = (b == 0) ? {mac, pkt_seq[7:0], 8'h5A} : {pkt_seq[15:0], 16'(b), $urandom};
      k = (b == nbeats - 1) ? 8'h0F : 8'hFF;
      l = (b == nbeats - 1);
      s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = l;
      s_axis_tuser  = 1'($urandom_range(0, 1));
      if (accept) begin
        if (b == 0) begin
          sb = (sb_sel == 0) ? {exp_id[2:0], exp_id[3:2]} :
               (sb_sel == 1) ? {rsp_port, rsp_seek} : 5'd0;
          exp_sb_q.push_back(sb);
          exp_chk_q.push_back({exp_id, mac});
          exp_id = (exp_id == 4'd15) ? 4'd1 : exp_id + 4'd1;
        end
        if (b < MAX) exp_q.push_back({l || (b == MAX - 1), k, d});
      end
    end
    if (abort_at == 0) begin
      @(negedge i_clk);
      s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
      repeat (gap) @(negedge i_clk);
    end
  endtask

  task automatic clear_model();
    exp_q.delete(); exp_sb_q.delete(); exp_chk_q.delete();
    exp_id = 4'd1; beats_out = 0;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    repeat (3) @(negedge i_clk);
    clear_model();
    i_rst = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_sb_q.size() != 0 || m_axis_tvalid) && n < 4000) begin
      @(negedge i_clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
    check({tag, "_sb"}, exp_sb_q.size(), 0);
    repeat (4) @(negedge i_clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_tvalid"},  m_axis_tvalid, 0);
    check({tag, "_tdata"},   m_axis_tdata, 0);
    check({tag, "_tkeep"},   m_axis_tkeep, 0);
    check({tag, "_tlast"},   m_axis_tlast, 0);
    check({tag, "_outport"}, o_m_outport, 0);
    check({tag, "_seek"},    o_m_seek_flag, 0);
    check({tag, "_chk_v"},   o_check_valid, 0);
    check({tag, "_chk_mac"}, o_check_mac, 0);
    check({tag, "_chk_id"},  o_check_id, 1);
    check({tag, "_drop"},    o_drop_cnt, 0);
    check({tag, "_tmo"},     o_timeout_cnt, 0);
    check({tag, "_iderr"},   o_id_err_cnt, 0);
    check({tag, "_state"},   o_egress_state, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int lens[6];
    lens = '{3, 17, 1, 64, 9, 30};

    // Reset state
    repeat (3) @(negedge i_clk);
    check_reset_values("rst");
    clear_model();
    i_rst = 1'b0;

    // 128-beat packet, fixed lookup result outport 2 / seek XBAR
    rsp_mode = 1; rsp_port = 3'd2; rsp_seek = 2'd1; tready_mode = 2;
    send_pkt(48'h8DBC5C4A0102, 128, 1'b1, 1, 2, 0);
    wait_drain("t1_drain");
    check("t1_beats", beats_out, 128);
    check("t1_drop", o_drop_cnt, 0);
    check("t1_tmo", o_timeout_cnt, 0);
    check("t1_iderr", o_id_err_cnt, 0);

    // 16 packets back to back: ids 1..15 then 1
    do_reset();
    rsp_mode = 2;
    for (int i = 0; i < 16; i++) send_pkt(48'h020000000000 + 48'(i), 4, 1'b1, 0, 0, 0);
    wait_drain("t2_drain");
    check("t2_chk_left", exp_chk_q.size(), 0);
    check("t2_drop", o_drop_cnt, 0);
    check("t2_next_id_model", exp_id, 2);

    // Random egress backpressure, then overfill with egress stalled
    tready_mode = 1;
    for (int i = 0; i < 6; i++) send_pkt(48'h0A0B0C0D0E00 + 48'(i), lens[i], 1'b1, 0, 3, 0);
    wait_drain("t3_drain");
    check("t3_drop0", o_drop_cnt, 0);
    tready_mode = 0;
    send_pkt(48'h111111111111, MAX, 1'b1, 0, 0, 0);
    send_pkt(48'h222222222222, MAX, 1'b1, 0, 0, 0);
    send_pkt(48'h333333333333, MAX, 1'b0, 0, 2, 0);
    check("t3_drop1", o_drop_cnt, 1);
    tready_mode = 1;
    wait_drain("t3_fill_drain");
    check("t3_drop_final", o_drop_cnt, 1);
    check("t3_iderr", o_id_err_cnt, 0);

    // Lookup never answers: default DDR result after the timeout, then late result
    do_reset();
    rsp_mode = 0; tready_mode = 2;
    send_pkt(48'hCAFE00000001, 4, 1'b1, 2, 0, 0);
    repeat (6) @(negedge i_clk);
    check("t4_tmo_early", o_timeout_cnt, 0);
    repeat (10) @(negedge i_clk);
    check("t4_tmo", o_timeout_cnt, 1);
    inj_id = 4'd1;
    inj_req_cnt++;
    repeat (4) @(negedge i_clk);
    check("t4_iderr", o_id_err_cnt, 1);
    wait_drain("t4_drain");
    check("t4_tmo_final", o_timeout_cnt, 1);

    // 200-beat packet is cut at 192 beats with tlast forced
    do_reset();
    rsp_mode = 2;
    send_pkt(48'hBEEF00000200, 200, 1'b1, 0, 2, 0);
    wait_drain("t5_drain");
    check("t5_beats", beats_out, MAX);
    check("t5_drop", o_drop_cnt, 1);

    // Reset during beat 40 of a packet, then a clean packet restarts at id 1
    send_pkt(48'hDEAD00000040, 100, 1'b1, 0, 0, 40);
    #2 i_rst = 1'b1;
    #1 check_reset_values("t6_rst");
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    repeat (2) @(negedge i_clk);
    clear_model();
    i_rst = 1'b0;
    send_pkt(48'h0123456789AB, 10, 1'b1, 0, 2, 0);
    wait_drain("t6_drain");
    check("t6_beats", beats_out, 10);
    check("t6_drop", o_drop_cnt, 0);
    check("t6_chk_left", exp_chk_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
